// File: rtl/sync_fifo_lvl.sv
// Single-clock valid/ready FIFO with optional fall-through, occupancy level,
// almost-full/almost-empty flags, synchronous flush and a high-watermark register.
module sync_fifo_lvl #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int FALL_THROUGH     = 0,
  parameter int AFULL_LVL        = BUFFER_DEPTH - 1,
  parameter int AEMPTY_LVL       = 1,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [DATA_WIDTH-1:0]       src_data_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  output logic [DATA_WIDTH-1:0]       dst_data_o,
  output logic                        dst_valid_o,
  input  logic                        dst_ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   level_o,
  output logic                        afull_o,
  output logic                        aempty_o,
  output logic [LOG_BUFFER_DEPTH:0]   peak_o,
  input  logic                        peak_clr_i
);

  localparam int PW = LOG_BUFFER_DEPTH + 1;
  localparam logic FT = (FALL_THROUGH != 0);

  logic [DATA_WIDTH-1:0]       mem_r [BUFFER_DEPTH];
  logic [PW-1:0]               wr_ptr_r;
  logic [PW-1:0]               rd_ptr_r;
  logic [PW-1:0]               level_r;
  logic [PW-1:0]               peak_r;
  logic [PW-1:0]               level_next_s;
  logic [LOG_BUFFER_DEPTH-1:0] wr_idx_s;
  logic [LOG_BUFFER_DEPTH-1:0] rd_idx_s;
  logic                        empty_s;
  logic                        full_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        bypass_s;
  logic                        push_stored_s;
  logic                        pop_stored_s;

  assign wr_idx_s = wr_ptr_r[LOG_BUFFER_DEPTH-1:0];
  assign rd_idx_s = rd_ptr_r[LOG_BUFFER_DEPTH-1:0];
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_idx_s == rd_idx_s) && (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]);

  // Ready depends only on registered state and flush, never on dst_ready_i.
  assign src_ready_o = !full_s && !flush_i;

  // Head selection: an empty fall-through FIFO presents the source word directly.
  always_comb begin
    dst_valid_o = 1'b0;
    dst_data_o  = mem_r[rd_idx_s];
    if (flush_i) begin
      dst_valid_o = 1'b0;
    end else if (FT && empty_s) begin
      dst_valid_o = src_valid_i;
    end else begin
      dst_valid_o = !empty_s;
    end
    if (FT && empty_s) begin
      dst_data_o = src_data_i;
    end else begin
      dst_data_o = mem_r[rd_idx_s];
    end
  end

  assign push_s        = src_valid_i && src_ready_o;
  assign pop_s         = dst_valid_o && dst_ready_i;
  assign bypass_s      = FT && empty_s && push_s && pop_s;
  assign push_stored_s = push_s && !bypass_s;
  assign pop_stored_s  = pop_s && !empty_s;

  // Next occupancy; a flush empties the FIFO regardless of handshakes.
  always_comb begin
    level_next_s = level_r;
    if (flush_i) begin
      level_next_s = {PW{1'b0}};
    end else begin
      level_next_s = level_r + PW'(push_stored_s) - PW'(pop_stored_s);
    end
  end

  // Pointer, level and high-watermark state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {PW{1'b0}};
      peak_r   <= {PW{1'b0}};
    end else begin
      if (flush_i) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_stored_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        if (pop_stored_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      level_r <= level_next_s;
      if (peak_clr_i) begin
        peak_r <= level_next_s;
      end else if (level_next_s > peak_r) begin
        peak_r <= level_next_s;
      end
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_stored_s) mem_r[wr_idx_s] <= src_data_i;
  end

  assign level_o  = level_r;
  assign peak_o   = peak_r;
  assign afull_o  = (level_r >= PW'(AFULL_LVL));
  assign aempty_o = (level_r <= PW'(AEMPTY_LVL));

  sync_fifo_lvl_chk u_chk (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_stored_s),
    .full      (full_s),
    .pop       (pop_stored_s),
    .dst_valid (dst_valid_o)
  );

endmodule

// Protocol checks: no write into a full FIFO, no read without a valid head.
module sync_fifo_lvl_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full,
  input logic pop,
  input logic dst_valid
);

  // Sampled on every edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full));
      assert (!(pop && !dst_valid));
    end
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench: FT=0 depth-8 instance plus FT=1 depth-4 instance.
module tb_sync_fifo_lvl;

  logic        clk = 1'b0;
  logic        rst;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        flush, src_valid, dst_ready, peak_clr;
  logic [31:0] src_data;
  logic        src_ready, dst_valid, afull, aempty;
  logic [31:0] dst_data;
  logic [3:0]  level, peak;

  logic        b_src_valid, b_dst_ready;
  logic [7:0]  b_src_data, b_dst_data;
  logic        b_src_ready, b_dst_valid, b_afull, b_aempty;
  logic [2:0]  b_level, b_peak;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.DATA_WIDTH(32), .BUFFER_DEPTH(8), .FALL_THROUGH(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .dst_data_o(dst_data), .dst_valid_o(dst_valid), .dst_ready_i(dst_ready),
    .level_o(level), .afull_o(afull), .aempty_o(aempty),
    .peak_o(peak), .peak_clr_i(peak_clr)
  );

  sync_fifo_lvl #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(1)) u_dut_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .src_data_i(b_src_data), .src_valid_i(b_src_valid), .src_ready_o(b_src_ready),
    .dst_data_o(b_dst_data), .dst_valid_o(b_dst_valid), .dst_ready_i(b_dst_ready),
    .level_o(b_level), .afull_o(b_afull), .aempty_o(b_aempty),
    .peak_o(b_peak), .peak_clr_i(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; src_valid = 1'b0; dst_ready = 1'b0; peak_clr = 1'b0;
    src_data = 32'h0;
    b_src_valid = 1'b0; b_dst_ready = 1'b0; b_src_data = 8'h0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd1);
    check("rst_dst_valid", 32'(dst_valid), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    check("rst_aempty", 32'(aempty), 32'd1);
    check("rst_peak", 32'(peak), 32'd0);

    // Fall-through: bypass when consumer ready, store when not.
    b_src_valid = 1'b1; b_src_data = 8'hA5; b_dst_ready = 1'b1;
    #1;
    check("ft_byp_valid", 32'(b_dst_valid), 32'd1);
    check("ft_byp_data", 32'(b_dst_data), 32'hA5);
    tick();
    check("ft_byp_level", 32'(b_level), 32'd0);
    check("ft_byp_peak", 32'(b_peak), 32'd0);
    b_dst_ready = 1'b0;
    #1;
    check("ft_st_valid", 32'(b_dst_valid), 32'd1);
    check("ft_st_data", 32'(b_dst_data), 32'hA5);
    tick();
    b_src_valid = 1'b0; b_src_data = 8'h3C;
    #1;
    check("ft_st_level", 32'(b_level), 32'd1);
    check("ft_st_held_data", 32'(b_dst_data), 32'hA5);
    check("ft_st_held_valid", 32'(b_dst_valid), 32'd1);
    check("ft_st_peak", 32'(b_peak), 32'd1);
    b_dst_ready = 1'b1;
    tick();
    b_dst_ready = 1'b0;
    #1;
    check("ft_pop_level", 32'(b_level), 32'd0);
    check("ft_pop_valid", 32'(b_dst_valid), 32'd0);

    // Fill to full with consumer stalled.
    src_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data = 32'((i + 1) * 32'h11);
      #1;
      check("fill_ready", 32'(src_ready), 32'd1);
      tick();
    end
    src_data = 32'h99;
    #1;
    check("full_ready", 32'(src_ready), 32'd0);
    check("full_level", 32'(level), 32'd8);
    check("full_afull", 32'(afull), 32'd1);
    check("full_aempty", 32'(aempty), 32'd0);
    check("full_peak", 32'(peak), 32'd8);
    src_valid = 1'b0;
    dst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_valid", 32'(dst_valid), 32'd1);
      check("drain_data", dst_data, 32'((i + 1) * 32'h11));
      check("drain_aempty", 32'(aempty), ((8 - i) <= 1) ? 32'd1 : 32'd0);
      tick();
    end
    dst_ready = 1'b0;
    #1;
    check("drained_valid", 32'(dst_valid), 32'd0);
    check("drained_level", 32'(level), 32'd0);

    // Hold level at 3 across the pointer wrap.
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data = 32'h100 + 32'(i);
      tick();
    end
    dst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      src_data = 32'h103 + 32'(i);
      #1;
      check("wrap_valid", 32'(dst_valid), 32'd1);
      check("wrap_ready", 32'(src_ready), 32'd1);
      check("wrap_data", dst_data, 32'h100 + 32'(i));
      check("wrap_level", 32'(level), 32'd3);
      tick();
    end
    src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wrap_tail", dst_data, 32'h114 + 32'(i));
      tick();
    end
    dst_ready = 1'b0;
    #1;
    check("wrap_empty", 32'(dst_valid), 32'd0);

    // Full with simultaneous pop: only the pop completes.
    src_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data = 32'h200 + 32'(i);
      tick();
    end
    src_data = 32'h2FF; dst_ready = 1'b1;
    #1;
    check("fp_ready", 32'(src_ready), 32'd0);
    check("fp_head", dst_data, 32'h200);
    tick();
    src_valid = 1'b0; dst_ready = 1'b0;
    #1;
    check("fp_level", 32'(level), 32'd7);
    check("fp_ready_after", 32'(src_ready), 32'd1);
    check("fp_next_head", dst_data, 32'h201);

    // Reduce to level 5, re-base the watermark, then flush.
    dst_ready = 1'b1;
    tick(); tick();
    dst_ready = 1'b0; peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    #1;
    check("lvl5_level", 32'(level), 32'd5);
    check("lvl5_peak", 32'(peak), 32'd5);
    flush = 1'b1; src_valid = 1'b1; dst_ready = 1'b1; src_data = 32'h2EE;
    #1;
    check("flush_src_ready", 32'(src_ready), 32'd0);
    check("flush_dst_valid", 32'(dst_valid), 32'd0);
    tick();
    flush = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    #1;
    check("flush_level", 32'(level), 32'd0);
    check("flush_peak", 32'(peak), 32'd5);
    check("flush_empty", 32'(dst_valid), 32'd0);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    #1;
    check("peak_clr", 32'(peak), 32'd0);

    // Reset beats flush and a pending push.
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = 32'h300 + 32'(i);
      tick();
    end
    #1;
    check("pre_rst_level", 32'(level), 32'd4);
    rst = 1'b1; flush = 1'b1; dst_ready = 1'b1; src_data = 32'h399;
    tick();
    rst = 1'b0; flush = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    #1;
    check("rst2_level", 32'(level), 32'd0);
    check("rst2_src_ready", 32'(src_ready), 32'd1);
    check("rst2_dst_valid", 32'(dst_valid), 32'd0);
    check("rst2_afull", 32'(afull), 32'd0);
    check("rst2_aempty", 32'(aempty), 32'd1);
    check("rst2_peak", 32'(peak), 32'd0);
    src_valid = 1'b1; src_data = 32'h3AB;
    tick();
    src_valid = 1'b0;
    #1;
    check("rt_valid", 32'(dst_valid), 32'd1);
    check("rt_data", dst_data, 32'h3AB);
    check("rt_level", 32'(level), 32'd1);
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    #1;
    check("rt_empty", 32'(dst_valid), 32'd0);
    check("rt_level0", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
